// File: rtl/video_bank_scheduler.sv
// -----------------------------------------------------------------------------
// video_bank_scheduler
// Ping-pong controller for the two video frame banks. The VGA path reads one
// bank while the SPI acquisition path fills the other; banks are exchanged
// only on a vertical-sync boundary once the new image has been shown for
// REPEAT display frames and the next image is complete. A late image is
// handled by repeating the current one (underrun) and retrying next vsync.
//
// Optional build macro: VIDEO_BANK_UNDERRUN_CNT_EN
//   When defined, adds output underrun_count[7:0], a saturating count of
//   underrun vsyncs since the last playback start.
//
// Reset is asynchronous on assertion; release is expected to be synchronised
// to CLK_40 by the surrounding reset tree.
// -----------------------------------------------------------------------------
module video_bank_scheduler #(
  parameter int REPEAT   = 2,
  parameter int REPEAT_W = 4
) (
  input  logic       CLK_40,
  input  logic       reset_n,
  input  logic       init,
  input  logic       stop,
  input  logic       vsync_pulse,
  input  logic       video_data_ready,
  output logic       start_req,
  output logic       read_bank1,
  output logic       read_bank2,
  output logic       write_bank1,
  output logic       write_bank2,
  output logic [3:0] bank_counter,
  output logic       playing
`ifdef VIDEO_BANK_UNDERRUN_CNT_EN
  ,
  output logic [7:0] underrun_count
`endif
);

  // Last value of the repeat counter before a swap becomes due.
  localparam logic [REPEAT_W-1:0] REP_LAST = REPEAT_W'(REPEAT - 1);
  localparam logic [REPEAT_W-1:0] REP_ONE  = REPEAT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    WAIT_VS = 2'd2,
    RUN     = 2'd3
  } state_t;

  // Registered state and outputs.
  state_t                state_r;
  logic                  cur_r;       // 0: bank1 is displayed, 1: bank2 is displayed
  logic                  filled_r;    // write bank holds a complete next image
  logic [REPEAT_W-1:0]   rep_cnt_r;   // vsyncs already spent on the current image
  logic [3:0]            bank_cnt_r;
  logic                  start_r;
  logic                  rd1_r;
  logic                  rd2_r;
  logic                  wr1_r;
  logic                  wr2_r;
  logic                  playing_r;

  // Next-state values.
  state_t                state_s;
  logic                  cur_s;
  logic                  filled_s;
  logic [REPEAT_W-1:0]   rep_cnt_s;
  logic [3:0]            bank_cnt_s;
  logic                  start_s;
  logic                  rd1_s;
  logic                  rd2_s;
  logic                  wr1_s;
  logic                  wr2_s;
  logic                  playing_s;

  // A ready pulse in the same cycle as a vsync counts as already filled.
  logic                  ready_s;
  assign ready_s = filled_r | video_data_ready;

  // State register and all registered outputs.
  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      cur_r      <= 1'b0;
      filled_r   <= 1'b0;
      rep_cnt_r  <= '0;
      bank_cnt_r <= 4'd0;
      start_r    <= 1'b0;
      rd1_r      <= 1'b0;
      rd2_r      <= 1'b0;
      wr1_r      <= 1'b0;
      wr2_r      <= 1'b0;
      playing_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      cur_r      <= cur_s;
      filled_r   <= filled_s;
      rep_cnt_r  <= rep_cnt_s;
      bank_cnt_r <= bank_cnt_s;
      start_r    <= start_s;
      rd1_r      <= rd1_s;
      rd2_r      <= rd2_s;
      wr1_r      <= wr1_s;
      wr2_r      <= wr2_s;
      playing_r  <= playing_s;
    end
  end

  // Next-state, bank-select and fetch-request decode.
  always_comb begin
    state_s    = state_r;
    cur_s      = cur_r;
    filled_s   = filled_r;
    rep_cnt_s  = rep_cnt_r;
    bank_cnt_s = bank_cnt_r;
    start_s    = 1'b0;
    rd1_s      = rd1_r;
    rd2_s      = rd2_r;
    wr1_s      = wr1_r;
    wr2_s      = wr2_r;

    case (state_r)
      IDLE: begin
        if (init) begin
          // First image always goes into bank1.
          state_s   = FILL;
          cur_s     = 1'b0;
          filled_s  = 1'b0;
          rep_cnt_s = '0;
          rd1_s     = 1'b0;
          rd2_s     = 1'b0;
          wr1_s     = 1'b1;
          wr2_s     = 1'b0;
          start_s   = 1'b1;
        end else begin
          state_s = IDLE;
          rd1_s   = 1'b0;
          rd2_s   = 1'b0;
          wr1_s   = 1'b0;
          wr2_s   = 1'b0;
        end
      end

      FILL: begin
        if (video_data_ready) begin
          state_s = WAIT_VS;
          wr1_s   = 1'b0;
        end else begin
          state_s = FILL;
        end
      end

      WAIT_VS: begin
        if (vsync_pulse) begin
          // Show bank1, start fetching the second image into bank2.
          state_s    = RUN;
          cur_s      = 1'b0;
          rd1_s      = 1'b1;
          rd2_s      = 1'b0;
          wr1_s      = 1'b0;
          wr2_s      = 1'b1;
          start_s    = 1'b1;
          rep_cnt_s  = '0;
          filled_s   = 1'b0;
          bank_cnt_s = bank_cnt_r + 4'd1;
        end else begin
          state_s = WAIT_VS;
        end
      end

      RUN: begin
        if (!vsync_pulse) begin
          filled_s = ready_s;
        end else if (rep_cnt_r < REP_LAST) begin
          // Current image still owes display frames.
          rep_cnt_s = rep_cnt_r + REP_ONE;
          filled_s  = ready_s;
        end else if (ready_s && !stop) begin
          // Exchange roles: the freshly filled bank becomes the read bank.
          cur_s      = ~cur_r;
          rd1_s      = cur_r;
          rd2_s      = ~cur_r;
          wr1_s      = ~cur_r;
          wr2_s      = cur_r;
          start_s    = 1'b1;
          filled_s   = 1'b0;
          rep_cnt_s  = '0;
          bank_cnt_s = bank_cnt_r + 4'd1;
        end else if (stop) begin
          state_s   = IDLE;
          rd1_s     = 1'b0;
          rd2_s     = 1'b0;
          wr1_s     = 1'b0;
          wr2_s     = 1'b0;
          filled_s  = 1'b0;
          rep_cnt_s = '0;
        end else begin
          // Underrun: keep showing the current image, swap stays due.
          rep_cnt_s = REP_LAST;
          filled_s  = 1'b0;
        end
      end

      default: begin
        state_s   = IDLE;
        cur_s     = 1'b0;
        filled_s  = 1'b0;
        rep_cnt_s = '0;
        rd1_s     = 1'b0;
        rd2_s     = 1'b0;
        wr1_s     = 1'b0;
        wr2_s     = 1'b0;
      end
    endcase

    playing_s = (state_s == WAIT_VS) || (state_s == RUN);
  end

  assign start_req    = start_r;
  assign read_bank1   = rd1_r;
  assign read_bank2   = rd2_r;
  assign write_bank1  = wr1_r;
  assign write_bank2  = wr2_r;
  assign bank_counter = bank_cnt_r;
  assign playing      = playing_r;

`ifdef VIDEO_BANK_UNDERRUN_CNT_EN
  logic [7:0] und_cnt_r;
  logic       underrun_s;
  logic       restart_s;

  // Detect the underrun vsync and the playback-start event.
  always_comb begin
    underrun_s = 1'b0;
    restart_s  = 1'b0;
    if ((state_r == RUN) && vsync_pulse && (rep_cnt_r == REP_LAST) && !ready_s && !stop) begin
      underrun_s = 1'b1;
    end else begin
      underrun_s = 1'b0;
    end
    if ((state_r == IDLE) && init) begin
      restart_s = 1'b1;
    end else begin
      restart_s = 1'b0;
    end
  end

  // Saturating underrun counter, cleared when playback starts.
  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      und_cnt_r <= 8'd0;
    end else if (restart_s) begin
      und_cnt_r <= 8'd0;
    end else if (underrun_s && (und_cnt_r != 8'hFF)) begin
      und_cnt_r <= und_cnt_r + 8'd1;
    end
  end

  assign underrun_count = und_cnt_r;
`endif

endmodule

// File: tb/tb_video_bank_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for video_bank_scheduler (REPEAT = 2).
// Directed vector table, hand-written multi-cycle sequences (underrun, async
// reset) and a randomized run compared against a behavioural playback model.
// -----------------------------------------------------------------------------
module tb_video_bank_scheduler;

  localparam int REPEAT = 2;

  logic       CLK_40 = 1'b0;
  logic       reset_n;
  logic       init, stop, vsync_pulse, video_data_ready;
  logic       start_req, read_bank1, read_bank2, write_bank1, write_bank2, playing;
  logic [3:0] bank_counter;
`ifdef VIDEO_BANK_UNDERRUN_CNT_EN
  logic [7:0] underrun_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK_40 = ~CLK_40;

  video_bank_scheduler #(.REPEAT(REPEAT), .REPEAT_W(4)) dut (
    .CLK_40           (CLK_40),
    .reset_n          (reset_n),
    .init             (init),
    .stop             (stop),
    .vsync_pulse      (vsync_pulse),
    .video_data_ready (video_data_ready),
    .start_req        (start_req),
    .read_bank1       (read_bank1),
    .read_bank2       (read_bank2),
    .write_bank1      (write_bank1),
    .write_bank2      (write_bank2),
    .bank_counter     (bank_counter),
    .playing          (playing)
`ifdef VIDEO_BANK_UNDERRUN_CNT_EN
    ,
    .underrun_count   (underrun_count)
`endif
  );

  // ---------------- behavioural playback model ----------------
  // m_mode: 0 stopped, 1 loading first image, 2 waiting for first vsync, 3 playing
  int m_mode, m_disp, m_shown, m_swaps, m_und;
  bit m_next, m_start;

  task automatic model_reset();
    m_mode = 0; m_disp = 0; m_shown = 0; m_swaps = 0; m_und = 0;
    m_next = 0; m_start = 0;
  endtask

  task automatic model_step(input bit i, input bit s, input bit v, input bit r);
    bit got;
    m_start = 0;
    case (m_mode)
      0: if (i) begin m_mode = 1; m_start = 1; m_und = 0; end
      1: if (r) m_mode = 2;
      2: if (v) begin
           m_mode = 3; m_disp = 1; m_shown = 0; m_next = 0;
           m_swaps = m_swaps + 1; m_start = 1;
         end
      default: begin
        got = m_next || r;
        if (!v) m_next = got;
        else begin
          m_shown = m_shown + 1;
          if (m_shown < REPEAT) m_next = got;
          else if (got && !s) begin
            m_disp = 3 - m_disp; m_swaps = m_swaps + 1; m_start = 1;
            m_shown = 0; m_next = 0;
          end else if (s) begin
            m_mode = 0; m_disp = 0;
          end else begin
            m_shown = REPEAT - 1; m_next = 0;
            if (m_und < 255) m_und = m_und + 1;
          end
        end
      end
    endcase
  endtask

  function automatic logic [9:0] mk(bit r1, bit r2, bit w1, bit w2, bit st, int cnt, bit pl);
    logic [3:0] c;
    c = 4'(cnt % 16);
    return {r1, r2, w1, w2, st, c, pl};
  endfunction

  function automatic logic [9:0] model_out();
    return mk(m_mode == 3 && m_disp == 1, m_mode == 3 && m_disp == 2,
              m_mode == 1 || (m_mode == 3 && m_disp == 2), m_mode == 3 && m_disp == 1,
              m_start, m_swaps, m_mode >= 2);
  endfunction

  function automatic logic [9:0] dut_out();
    return {read_bank1, read_bank2, write_bank1, write_bank2, start_req, bank_counter, playing};
  endfunction

  task automatic check_vec(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rd1rd2wr1wr2_st_cnt_pl=%b expected %b", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

`ifdef VIDEO_BANK_UNDERRUN_CNT_EN
  task automatic check_und(input string name, input int exp);
    checks++;
    if (underrun_count !== 8'(exp)) begin
      errors++;
      $display("FAIL %s: underrun_count got %0d expected %0d", name, underrun_count, exp);
    end
  endtask
`endif

  // One clock: drive inputs, take the edge, advance the model, then sample.
  task automatic cycle(input bit i, input bit s, input bit v, input bit r);
    init = i; stop = s; vsync_pulse = v; video_data_ready = r;
    @(posedge CLK_40);
    model_step(i, s, v, r);
    #1;
    init = 1'b0; stop = 1'b0; vsync_pulse = 1'b0; video_data_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    init = 1'b0; stop = 1'b0; vsync_pulse = 1'b0; video_data_ready = 1'b0;
    model_reset();
    #1;
    check_vec("reset_state", dut_out(), 10'd0);
    @(negedge CLK_40);
    reset_n = 1'b1;
    @(posedge CLK_40);
    #1;
  endtask

  typedef struct {
    bit         i, s, v, r;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[15];
  bit   prev_start;
  bit   rs;

  initial begin
    // Directed table: inputs for one cycle and the outputs right after it.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, 1, 0, 1, 0, 0)}; // init
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 1, 0, 0, 0, 0)}; // start_req one cycle only
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 1)}; // bank1 filled
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 1, 1, 1, 1)}; // first vsync
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 1, 0, 1, 1)};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 1, 0, 1, 1)}; // 1st vsync, not due
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 1, 0, 1, 1)}; // ready
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, mk(0, 1, 1, 0, 1, 2, 1)}; // due -> swap
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(0, 1, 1, 0, 0, 2, 1)};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, mk(0, 1, 1, 0, 0, 2, 1)};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, mk(1, 0, 0, 1, 1, 3, 1)}; // ready+vsync same edge
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 1, 0, 3, 1)};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 3, 0)}; // stop at due point
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, 1, 0, 1, 3, 0)}; // restart
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, 1, 0, 0, 3, 0)}; // init in FILL ignored

    do_reset();
    for (int k = 0; k < 15; k++) begin
      cycle(tbl[k].i, tbl[k].s, tbl[k].v, tbl[k].r);
      check_vec($sformatf("table_%0d", k), dut_out(), tbl[k].exp);
      check_vec($sformatf("table_model_%0d", k), dut_out(), model_out());
    end

    // Underrun across three due vsyncs, then recovery.
    do_reset();
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);          // not yet due
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 1, 0);        // due but nothing ready
      check_vec($sformatf("underrun_hold_%0d", k), dut_out(), mk(1, 0, 0, 1, 0, 1, 1));
    end
`ifdef VIDEO_BANK_UNDERRUN_CNT_EN
    check_und("underrun_count_3", 3);
`endif
    cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 0);
    check_vec("underrun_recover_swap", dut_out(), mk(0, 1, 1, 0, 1, 2, 1));
    cycle(0, 0, 0, 0);

    // Asynchronous reset in mid-RUN, away from a clock edge.
    #3;
    reset_n = 1'b0;
    #1;
    check_vec("async_reset_mid_run", dut_out(), 10'd0);
`ifdef VIDEO_BANK_UNDERRUN_CNT_EN
    check_und("async_reset_underrun", 0);
`endif
    model_reset();
    @(negedge CLK_40);
    reset_n = 1'b1;
    @(posedge CLK_40);
    #1;
    cycle(1, 0, 0, 0);
    check_vec("restart_after_reset", dut_out(), mk(0, 0, 1, 0, 1, 0, 0));

    // Randomized run against the model.
    do_reset();
    prev_start = 1'b0;
    rs = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 39) == 0) rs = ~rs;
      cycle($urandom_range(0, 24) == 0, rs, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
      check_vec($sformatf("random_%0d", n), dut_out(), model_out());
`ifdef VIDEO_BANK_UNDERRUN_CNT_EN
      check_und($sformatf("random_und_%0d", n), m_und);
`endif
      check_bit("no_rd_wr_same_bank", (read_bank1 & write_bank1) | (read_bank2 & write_bank2), 1'b0);
      if (prev_start) check_bit("start_req_not_consecutive", start_req, 1'b0);
      prev_start = start_req;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
